// File: rtl/program_counter_if.sv
// program_counter_if: command/load bus and registered PC outputs of the 65C02 program counter.
interface program_counter_if #(parameter int WIDTH = 8);
  logic             i_load_lo;
  logic             i_load_hi;
  logic             i_inc;
  logic             i_branch;
  logic [WIDTH-1:0] i_adl;
  logic [WIDTH-1:0] i_adh;
  logic [WIDTH-1:0] i_offset;
  logic [WIDTH-1:0] o_pcl;
  logic [WIDTH-1:0] o_pch;
  logic             o_busy;
  modport master(output i_load_lo, i_load_hi, i_inc, i_branch, i_adl, i_adh, i_offset,
                 input o_pcl, o_pch, o_busy);
  modport slave(input i_load_lo, i_load_hi, i_inc, i_branch, i_adl, i_adh, i_offset,
                output o_pcl, o_pch, o_busy);
endinterface

// File: rtl/program_counter.sv
// program_counter: 65C02 PC with split byte registers, load, increment and relative branch.
// A branch crossing a page updates PCL first and corrects PCH one cycle later (BUSY high).
module program_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [2*WIDTH-1:0] RESET_PC = 16'hFFFC
) (
  input logic               clk,
  input logic               rst_n,
  program_counter_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, FIXUP = 1'b1} state_t;
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_pcl, r_pch, w_pcl, w_pch;
  logic               r_dir, w_dir;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_inc;
  logic               w_cross;
  assign w_sum   = {1'b0, r_pcl} + {1'b0, bus.i_offset};
  assign w_inc   = {r_pch, r_pcl} + (2*WIDTH)'(1);
  // forward carry or backward borrow both leave the current page
  assign w_cross = w_sum[WIDTH] ^ bus.i_offset[WIDTH-1];
  always_comb begin
    w_next = r_state;
    w_pcl  = r_pcl;
    w_pch  = r_pch;
    w_dir  = r_dir;
    if (r_state == FIXUP) begin
      w_pch  = r_dir ? r_pch - WIDTH'(1) : r_pch + WIDTH'(1);
      w_next = IDLE;
    end else if (bus.i_load_lo || bus.i_load_hi) begin
      w_pcl = bus.i_load_lo ? bus.i_adl : r_pcl;
      w_pch = bus.i_load_hi ? bus.i_adh : r_pch;
    end else if (bus.i_branch) begin
      w_pcl  = w_sum[WIDTH-1:0];
      w_next = w_cross ? FIXUP : IDLE;
      w_dir  = bus.i_offset[WIDTH-1];
    end else if (bus.i_inc) begin
      {w_pch, w_pcl} = w_inc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pcl   <= RESET_PC[WIDTH-1:0];
      r_pch   <= RESET_PC[2*WIDTH-1:WIDTH];
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pcl   <= w_pcl;
      r_pch   <= w_pch;
      r_dir   <= w_dir;
    end
  end
  assign bus.o_pcl  = r_pcl;
  assign bus.o_pch  = r_pch;
  assign bus.o_busy = (r_state == FIXUP);
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed vector table, corner sequences and randomized run against a PC model.
module tb_program_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  program_counter_if #(.WIDTH(8)) pif();
  program_counter dut(.clk(clk), .rst_n(rst_n), .bus(pif.slave));
  typedef struct {
    logic       ld_lo, ld_hi, inc, br;
    logic [7:0] adl, adh, off;
    logic [15:0] pc;
    logic       busy;
  } vec_t;
  vec_t vecs[20];
  logic [15:0] m_pc;
  logic        m_busy;
  logic [15:0] m_target;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_state(input string name, input logic [15:0] pc, input logic busy);
    check({name, " pc"}, {pif.o_pch, pif.o_pcl}, pc);
    check({name, " busy"}, {15'd0, pif.o_busy}, {15'd0, busy});
  endtask
  // Reference: a branch ends at PC + signed offset; it takes two cycles when the high byte changes.
  task automatic model_step();
    logic [15:0] t, mid;
    if (m_busy) begin
      m_pc = m_target;
      m_busy = 1'b0;
    end else if (pif.i_load_lo || pif.i_load_hi) begin
      if (pif.i_load_lo) m_pc[7:0] = pif.i_adl;
      if (pif.i_load_hi) m_pc[15:8] = pif.i_adh;
    end else if (pif.i_branch) begin
      t = m_pc + {{8{pif.i_offset[7]}}, pif.i_offset};
      mid = {m_pc[15:8], t[7:0]};
      if (mid != t) begin
        m_busy = 1'b1;
        m_target = t;
      end
      m_pc = mid;
    end else if (pif.i_inc) begin
      m_pc = m_pc + 16'd1;
    end
  endtask
  task automatic drive(input logic lo, hi, inc, br, input logic [7:0] adl, adh, off);
    pif.i_load_lo = lo; pif.i_load_hi = hi; pif.i_inc = inc; pif.i_branch = br;
    pif.i_adl = adl; pif.i_adh = adh; pif.i_offset = off;
  endtask
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    m_pc = 16'hFFFC;
    m_busy = 1'b0;
    m_target = 16'h0000;
  endtask
  initial begin
    vecs[0]  = '{0,0,1,0, 8'h00,8'h00,8'h00, 16'hFFFD,0};
    vecs[1]  = '{1,1,0,0, 8'hFF,8'hFF,8'h00, 16'hFFFF,0};
    vecs[2]  = '{0,0,1,0, 8'h00,8'h00,8'h00, 16'h0000,0};
    vecs[3]  = '{1,1,0,0, 8'hF0,8'h12,8'h00, 16'h12F0,0};
    vecs[4]  = '{0,0,0,1, 8'h00,8'h00,8'h20, 16'h1210,1};
    vecs[5]  = '{0,0,0,0, 8'h00,8'h00,8'h00, 16'h1310,0};
    vecs[6]  = '{1,1,0,0, 8'h10,8'h12,8'h00, 16'h1210,0};
    vecs[7]  = '{0,0,0,1, 8'h00,8'h00,8'hE0, 16'h12F0,1};
    vecs[8]  = '{0,0,0,0, 8'h00,8'h00,8'h00, 16'h11F0,0};
    vecs[9]  = '{1,1,0,0, 8'h10,8'h12,8'h00, 16'h1210,0};
    vecs[10] = '{0,0,0,1, 8'h00,8'h00,8'h05, 16'h1215,0};
    vecs[11] = '{1,1,0,0, 8'h10,8'h12,8'h00, 16'h1210,0};
    vecs[12] = '{0,0,0,1, 8'h00,8'h00,8'hFB, 16'h120B,0};
    vecs[13] = '{1,1,0,0, 8'h00,8'h40,8'h00, 16'h4000,0};
    vecs[14] = '{1,0,1,1, 8'h55,8'h00,8'h20, 16'h4055,0};
    vecs[15] = '{1,1,0,0, 8'hF0,8'h12,8'h00, 16'h12F0,0};
    vecs[16] = '{0,0,0,1, 8'h00,8'h00,8'h20, 16'h1210,1};
    vecs[17] = '{0,1,1,0, 8'h00,8'hAA,8'h00, 16'h1310,0};
    vecs[18] = '{0,0,1,0, 8'h00,8'h00,8'h00, 16'h1311,0};
    vecs[19] = '{0,1,0,0, 8'h00,8'h34,8'h00, 16'h3411,0};
    drive(0,0,0,0, 8'h00,8'h00,8'h00);
    model_reset();
    #12;
    check_state("reset", 16'hFFFC, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].ld_lo, vecs[i].ld_hi, vecs[i].inc, vecs[i].br, vecs[i].adl, vecs[i].adh, vecs[i].off);
      cycle();
      check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].busy);
    end
    // asynchronous reset without a clock edge, then INC right after release
    drive(0,0,0,0, 8'h00,8'h00,8'h00);
    #2 rst_n = 1'b0;
    #1 check_state("async reset", 16'hFFFC, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
    drive(0,0,1,0, 8'h00,8'h00,8'h00);
    cycle();
    check_state("inc after reset", 16'hFFFD, 1'b0);
    // reset while fixup pending aborts the PCH correction
    drive(1,1,0,0, 8'hF0,8'h12,8'h00);
    cycle();
    drive(0,0,0,1, 8'h00,8'h00,8'h20);
    cycle();
    check_state("pre-abort", 16'h1210, 1'b1);
    drive(0,0,0,0, 8'h00,8'h00,8'h00);
    #2 rst_n = 1'b0;
    #1 check_state("reset in fixup", 16'hFFFC, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
    cycle();
    check_state("no fixup after reset", 16'hFFFC, 1'b0);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0,5) == 0, $urandom_range(0,5) == 0, $urandom_range(0,1) == 1,
            $urandom_range(0,1) == 1, 8'($urandom), 8'($urandom), 8'($urandom));
      cycle();
      check_state("random", m_pc, m_busy);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/program_counter.md
# program_counter

- 16-bit 65C02 program counter, held as separate low and high byte registers.
- Supports load, increment and relative-branch with 6502-style page-cross fixup.
- PCL_OUT is one of the sources selected onto the internal address bus low; PCH_OUT feeds the internal address bus high.
- Commands come from the decode/timing logic each cycle. Loads take their values from the ADL/ADH internal buses.

## Interface
Parameters:
- WIDTH, 8, width of each PC byte register
- RESET_PC, 16'hFFFC, value {PCH,PCL} takes on reset

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST_N  input  1  asynchronous, active-low reset
- LOAD_LO  input  1  load PCL from ADL_IN
- LOAD_HI  input  1  load PCH from ADH_IN
- INC  input  1  increment {PCH,PCL} by 1
- BRANCH  input  1  add sign-extended OFFSET to PC
- ADL_IN  input  WIDTH  low-byte load data
- ADH_IN  input  WIDTH  high-byte load data
- OFFSET  input  WIDTH  two's-complement branch displacement
- PCL_OUT  output  WIDTH  registered PC low byte
- PCH_OUT  output  WIDTH  registered PC high byte
- BUSY  output  1  high while page-cross fixup is pending

## Operation
- State machine: two states, IDLE and FIXUP.
- Reset (RST_N low, asynchronous):
  - {PCH_OUT,PCL_OUT} = RESET_PC, BUSY = 0, state = IDLE.
  - Holds until RST_N rises. Reset asserted mid-FIXUP aborts the fixup.
- IDLE command priority: LOAD (either byte) > BRANCH > INC > hold.
  - LOAD_LO / LOAD_HI are independent. Each loads only its own byte; the unloaded byte holds.
  - Any LOAD asserted suppresses BRANCH and INC that cycle.
  - INC: 16-bit increment, mod 2^16, completed in one cycle. PCL carry propagates into PCH in the same edge; 0xFFFF -> 0x0000.
  - BRANCH: PCL <= (PCL + OFFSET) mod 256, PCH unchanged. C = carry out of the unsigned 8-bit add, N = OFFSET[WIDTH-1].
    - Page cross when (C=1 and N=0) or (C=0 and N=1). Go to FIXUP and latch dir = N.
    - No page cross: stay in IDLE.
- FIXUP:
  - PCH <= PCH + 1 if dir = 0, PCH - 1 if dir = 1 (mod 256). PCL holds. Return to IDLE.
  - All commands (LOAD_LO, LOAD_HI, INC, BRANCH) are ignored and not queued. Upstream must not issue commands while BUSY = 1.
- BUSY = 1 exactly while state = FIXUP. It is a registered output.

## Timing
- All outputs are registered. A command sampled at edge N is visible on the outputs after edge N.
- LOAD, INC, and BRANCH without page cross: 1-cycle latency, BUSY stays 0.
- BRANCH with page cross:
  - Edge N: PCL updated, BUSY -> 1.
  - Edge N+1: PCH corrected, BUSY -> 0.
  - Total 2 cycles; the intermediate PCL/PCH value is visible for exactly one cycle.
- Back-to-back commands in IDLE are accepted every cycle.
- The first command after FIXUP is accepted at edge N+2.
- Reset release: the first command is accepted on the first rising edge with RST_N high.

## Test plan
- Reset: pulse RST_N low mid-cycle, no clock edge -> outputs immediately 0xFC/0xFF, BUSY=0. Release and issue INC -> PC = 0xFFFD.
- Increment wrap: LOAD_LO=1, LOAD_HI=1 with ADL=0xFF, ADH=0xFF, then INC -> PC 0xFFFF then 0x0000, BUSY never asserts.
- Forward page cross: PC=0x12F0, BRANCH with OFFSET=0x20 -> PC 0x1210 with BUSY=1, next cycle PC 0x1310 with BUSY=0.
- Backward page cross and no-cross:
  - PC=0x1210, OFFSET=0xE0 -> 0x12F0 with BUSY=1, then 0x11F0.
  - PC=0x1210, OFFSET=0x05 -> 0x1215 in one cycle, BUSY=0.
  - PC=0x1210, OFFSET=0xFB -> 0x120B in one cycle, BUSY=0.
- Priority and ignore:
  - PC=0x4000, LOAD_LO=1 (ADL=0x55), INC=1, BRANCH=1 together -> PC 0x4055.
  - During FIXUP, assert LOAD_HI with ADH=0xAA and INC -> both ignored; corrected PCH wins.
- Reset mid-fixup: RST_N low while BUSY=1 -> PC=0xFFFC, BUSY=0, state IDLE. After release, no PCH correction is applied.
